// File: rtl/led_seq_pkg.sv
// Shared constants and types for the LED mode sequencer: modes, speed limits,
// key bit positions and the single-LED pattern helper.
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_FLOW   = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_BOUNCE = 2'd3
   } mode_e;

   localparam logic [3:0] SPEED_MIN = 4'd1;
   localparam logic [3:0] SPEED_MAX = 4'd8;

   localparam int KEY_MODE  = 0;
   localparam int KEY_UP    = 1;
   localparam int KEY_DN    = 2;
   localparam int KEY_PAUSE = 3;

   localparam logic [3:0] LED_ALL_DARK = 4'b1111;
   localparam logic [3:0] LED_ALL_LIT  = 4'b0000;

   // Active-low drive with only the LED at pos lit.
   function automatic logic [3:0] pos_led(input logic [1:0] pos);
      return ~(4'b0001 << pos);
   endfunction

endpackage

// File: rtl/led_step_timer.sv
// Pattern step timer: a unit prescaler feeding a step counter whose limit
// follows the current speed, producing a one-cycle step pulse.
module led_step_timer #(
   parameter int STEP_UNIT = 5_000_000
) (
   input  logic       clk,
   input  logic       rest,
   input  logic       run,
   input  logic       clear,
   input  logic [3:0] speed,
   output logic       step
);

   localparam int            UW        = (STEP_UNIT > 1) ? $clog2(STEP_UNIT) : 1;
   localparam logic [UW-1:0] UNIT_LAST = UW'(STEP_UNIT - 1);

   logic [UW-1:0] unit_cnt_r;
   logic [2:0]    step_cnt_r;
   logic          unit_tick_s;
   logic [3:0]    limit_s;

   assign unit_tick_s = run && (unit_cnt_r == UNIT_LAST);
   assign limit_s     = 4'd8 - speed;
   // >= lets a speed increase past the current count step on the next unit tick.
   assign step        = unit_tick_s && ({1'b0, step_cnt_r} >= limit_s);

   // Unit and step counters; clear restarts a fresh period, idle when not running.
   always_ff @(posedge clk) begin
      if (!rest) begin
         unit_cnt_r <= '0;
         step_cnt_r <= 3'd0;
      end else if (clear) begin
         unit_cnt_r <= '0;
         step_cnt_r <= 3'd0;
      end else if (run) begin
         unit_cnt_r <= unit_tick_s ? '0 : unit_cnt_r + UW'(1);
         if (step) begin
            step_cnt_r <= 3'd0;
         end else if (unit_tick_s) begin
            step_cnt_r <= step_cnt_r + 3'd1;
         end
      end
   end

endmodule

// File: rtl/led_mode_seq.sv
// LED pattern engine: decodes key press pulses into mode/speed/pause control
// and steps an active-low 4-LED pattern (OFF, FLOW, BLINK, BOUNCE).
module led_mode_seq
   import led_seq_pkg::*;
#(
   parameter int STEP_UNIT = 5_000_000,
   parameter int SPEED_RST = 4
) (
   input  logic       clk,
   input  logic       rest,
   input  logic [3:0] key_pulse,
   output logic [3:0] led,
   output logic [1:0] mode,
   output logic [3:0] speed,
   output logic       paused
);

   mode_e      mode_r, mode_n;
   logic [3:0] speed_r, speed_n;
   logic       paused_r, paused_n;
   logic [3:0] led_r, led_n;
   logic [1:0] pos_r, pos_n;
   logic       dir_up_r, dir_up_n;
   logic       phase_r, phase_n;
   logic       step_s;

   led_step_timer #(.STEP_UNIT(STEP_UNIT)) u_timer (
      .clk   (clk),
      .rest  (rest),
      .run   (!paused_r),
      .clear (key_pulse[KEY_MODE]),
      .speed (speed_r),
      .step  (step_s)
   );

   // Next-state: key decode, mode entry patterns and per-mode stepping.
   always_comb begin
      mode_n   = mode_r;
      speed_n  = speed_r;
      paused_n = paused_r;
      led_n    = led_r;
      pos_n    = pos_r;
      dir_up_n = dir_up_r;
      phase_n  = phase_r;

      if (key_pulse[KEY_UP] && !key_pulse[KEY_DN]) begin
         speed_n = (speed_r < SPEED_MAX) ? speed_r + 4'd1 : SPEED_MAX;
      end else if (key_pulse[KEY_DN] && !key_pulse[KEY_UP]) begin
         speed_n = (speed_r > SPEED_MIN) ? speed_r - 4'd1 : SPEED_MIN;
      end else begin
         speed_n = speed_r;
      end

      if (key_pulse[KEY_PAUSE]) begin
         paused_n = !paused_r;
      end else begin
         paused_n = paused_r;
      end

      // A mode change swallows any coincident step and shows the entry pattern.
      if (key_pulse[KEY_MODE]) begin
         mode_n   = mode_e'(mode_r + 2'd1);
         pos_n    = 2'd0;
         dir_up_n = 1'b1;
         phase_n  = 1'b0;
         case (mode_n)
            MODE_FLOW:   led_n = pos_led(2'd0);
            MODE_BLINK:  led_n = LED_ALL_LIT;
            MODE_BOUNCE: led_n = pos_led(2'd0);
            default:     led_n = LED_ALL_DARK;
         endcase
      end else if (step_s) begin
         case (mode_r)
            MODE_FLOW: begin
               pos_n = pos_r + 2'd1;
               led_n = pos_led(pos_n);
            end
            MODE_BLINK: begin
               phase_n = !phase_r;
               led_n   = phase_n ? LED_ALL_DARK : LED_ALL_LIT;
            end
            MODE_BOUNCE: begin
               if (dir_up_r) begin
                  pos_n    = pos_r + 2'd1;
                  dir_up_n = (pos_n != 2'd3);
               end else begin
                  pos_n    = pos_r - 2'd1;
                  dir_up_n = (pos_n == 2'd0);
               end
               led_n = pos_led(pos_n);
            end
            default: led_n = LED_ALL_DARK;
         endcase
      end else begin
         led_n = led_r;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rest) begin
         mode_r   <= MODE_OFF;
         speed_r  <= 4'(SPEED_RST);
         paused_r <= 1'b0;
         led_r    <= LED_ALL_DARK;
         pos_r    <= 2'd0;
         dir_up_r <= 1'b1;
         phase_r  <= 1'b0;
      end else begin
         mode_r   <= mode_n;
         speed_r  <= speed_n;
         paused_r <= paused_n;
         led_r    <= led_n;
         pos_r    <= pos_n;
         dir_up_r <= dir_up_n;
         phase_r  <= phase_n;
      end
   end

   assign led    = led_r;
   assign mode   = mode_r;
   assign speed  = speed_r;
   assign paused = paused_r;

endmodule

// File: tb/tb_led_mode_seq.sv
// Scenario bench for led_mode_seq: expected {led,mode,speed,paused} values are
// queued when stimulus is applied and compared once the DUT has clocked.
module tb_led_mode_seq;

   localparam int STEP_UNIT = 4;
   localparam int SPEED_RST = 4;

   typedef struct {
      string       name;
      logic [10:0] v;
   } exp_t;

   logic       clk = 1'b0;
   logic       rest;
   logic [3:0] key_pulse;
   logic [3:0] led;
   logic [1:0] mode;
   logic [3:0] speed;
   logic       paused;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   led_mode_seq #(.STEP_UNIT(STEP_UNIT), .SPEED_RST(SPEED_RST)) dut (
      .clk       (clk),
      .rest      (rest),
      .key_pulse (key_pulse),
      .led       (led),
      .mode      (mode),
      .speed     (speed),
      .paused    (paused)
   );

   function automatic logic [10:0] obs();
      return {led, mode, speed, paused};
   endfunction

   function automatic exp_t ev(input string nm, input logic [3:0] l, input logic [1:0] m,
                               input logic [3:0] s, input logic p);
      exp_t e;
      e.name = nm;
      e.v    = {l, m, s, p};
      return e;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic pulse(input logic [3:0] k);
      key_pulse = k;
      tick(1);
      key_pulse = 4'b0000;
   endtask

   task automatic test_reset();
      exp_t e;
      rest = 1'b0;
      key_pulse = 4'b0000;
      exp_q.push_back(ev("reset", 4'b1111, 2'd0, 4'd4, 1'b0));
      tick(3);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      rest = 1'b1;
      for (int i = 0; i < 100; i++) begin
         exp_q.push_back(ev("idle", 4'b1111, 2'd0, 4'd4, 1'b0));
         tick(1);
         e = exp_q.pop_front(); n_cmp++;
         if (obs() !== e.v) begin n_bad++; $display("FAIL %s[%0d]: got %b want %b", e.name, i, obs(), e.v); end
      end
   endtask

   task automatic test_flow();
      exp_t e;
      logic [3:0] seq [4];
      seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
      exp_q.push_back(ev("flow_entry", 4'b1110, 2'd1, 4'd4, 1'b0));
      pulse(4'b0001);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(ev("flow_hold", (i == 0) ? 4'b1110 : seq[i-1], 2'd1, 4'd4, 1'b0));
         exp_q.push_back(ev("flow_step", seq[i], 2'd1, 4'd4, 1'b0));
         tick(19);
         e = exp_q.pop_front(); n_cmp++;
         if (obs() !== e.v) begin n_bad++; $display("FAIL %s[%0d]: got %b want %b", e.name, i, obs(), e.v); end
         tick(1);
         e = exp_q.pop_front(); n_cmp++;
         if (obs() !== e.v) begin n_bad++; $display("FAIL %s[%0d]: got %b want %b", e.name, i, obs(), e.v); end
      end
      // Reset mid-pattern with every key pulsing in the same cycle.
      tick(7);
      exp_q.push_back(ev("reset_mid_flow", 4'b1111, 2'd0, 4'd4, 1'b0));
      rest = 1'b0;
      key_pulse = 4'b1111;
      tick(1);
      key_pulse = 4'b0000;
      rest = 1'b1;
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
   endtask

   task automatic test_bounce();
      exp_t e;
      logic [3:0] spd_up [5];
      logic [3:0] entry_led [3];
      logic [1:0] bpos [7];
      logic [3:0] prev_led;
      spd_up[0] = 4'd5; spd_up[1] = 4'd6; spd_up[2] = 4'd7; spd_up[3] = 4'd8; spd_up[4] = 4'd8;
      entry_led[0] = 4'b1110; entry_led[1] = 4'b0000; entry_led[2] = 4'b1110;
      bpos[0] = 2'd1; bpos[1] = 2'd2; bpos[2] = 2'd3; bpos[3] = 2'd2;
      bpos[4] = 2'd1; bpos[5] = 2'd0; bpos[6] = 2'd1;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(ev("speed_up", 4'b1111, 2'd0, spd_up[i], 1'b0));
         pulse(4'b0010);
         e = exp_q.pop_front(); n_cmp++;
         if (obs() !== e.v) begin n_bad++; $display("FAIL %s[%0d]: got %b want %b", e.name, i, obs(), e.v); end
      end
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(ev("to_bounce", entry_led[i], 2'(i + 1), 4'd8, 1'b0));
         pulse(4'b0001);
         e = exp_q.pop_front(); n_cmp++;
         if (obs() !== e.v) begin n_bad++; $display("FAIL %s[%0d]: got %b want %b", e.name, i, obs(), e.v); end
      end
      prev_led = 4'b1110;
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(ev("bounce_hold", prev_led, 2'd3, 4'd8, 1'b0));
         prev_led = ~(4'b0001 << bpos[i]);
         exp_q.push_back(ev("bounce_step", prev_led, 2'd3, 4'd8, 1'b0));
         tick(3);
         e = exp_q.pop_front(); n_cmp++;
         if (obs() !== e.v) begin n_bad++; $display("FAIL %s[%0d]: got %b want %b", e.name, i, obs(), e.v); end
         tick(1);
         e = exp_q.pop_front(); n_cmp++;
         if (obs() !== e.v) begin n_bad++; $display("FAIL %s[%0d]: got %b want %b", e.name, i, obs(), e.v); end
      end
      // Walk speed down past the floor; only speed is predictable meanwhile.
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(ev("speed_dn", 4'b0000, 2'd0, (i < 7) ? 4'(7 - i) : 4'd1, 1'b0));
         pulse(4'b0100);
         e = exp_q.pop_front(); n_cmp++;
         if (speed !== e.v[4:1]) begin n_bad++; $display("FAIL %s[%0d]: got speed %0d want %0d", e.name, i, speed, e.v[4:1]); end
      end
      exp_q.push_back(ev("rebounce_off", 4'b1111, 2'd0, 4'd1, 1'b0));
      exp_q.push_back(ev("rebounce_flow", 4'b1110, 2'd1, 4'd1, 1'b0));
      exp_q.push_back(ev("rebounce_blink", 4'b0000, 2'd2, 4'd1, 1'b0));
      exp_q.push_back(ev("rebounce_bounce", 4'b1110, 2'd3, 4'd1, 1'b0));
      for (int i = 0; i < 4; i++) begin
         pulse(4'b0001);
         e = exp_q.pop_front(); n_cmp++;
         if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      end
      exp_q.push_back(ev("slow_hold", 4'b1110, 2'd3, 4'd1, 1'b0));
      exp_q.push_back(ev("slow_step", 4'b1101, 2'd3, 4'd1, 1'b0));
      tick(31);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      tick(1);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
   endtask

   task automatic test_pause();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(ev("speed_back", 4'b0000, 2'd3, 4'(2 + i), 1'b0));
         pulse(4'b0010);
         e = exp_q.pop_front(); n_cmp++;
         if (speed !== e.v[4:1]) begin n_bad++; $display("FAIL %s[%0d]: got speed %0d want %0d", e.name, i, speed, e.v[4:1]); end
      end
      exp_q.push_back(ev("to_off", 4'b1111, 2'd0, 4'd4, 1'b0));
      exp_q.push_back(ev("to_flow", 4'b1110, 2'd1, 4'd4, 1'b0));
      exp_q.push_back(ev("to_blink", 4'b0000, 2'd2, 4'd4, 1'b0));
      for (int i = 0; i < 3; i++) begin
         pulse(4'b0001);
         e = exp_q.pop_front(); n_cmp++;
         if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      end
      tick(9);
      exp_q.push_back(ev("pause_on", 4'b0000, 2'd2, 4'd4, 1'b1));
      pulse(4'b1000);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      for (int i = 0; i < 100; i++) begin
         exp_q.push_back(ev("paused_hold", 4'b0000, 2'd2, 4'd4, 1'b1));
         tick(1);
         e = exp_q.pop_front(); n_cmp++;
         if (obs() !== e.v) begin n_bad++; $display("FAIL %s[%0d]: got %b want %b", e.name, i, obs(), e.v); end
      end
      exp_q.push_back(ev("pause_off", 4'b0000, 2'd2, 4'd4, 1'b0));
      pulse(4'b1000);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      exp_q.push_back(ev("resume_hold", 4'b0000, 2'd2, 4'd4, 1'b0));
      exp_q.push_back(ev("resume_toggle", 4'b1111, 2'd2, 4'd4, 1'b0));
      exp_q.push_back(ev("full_hold", 4'b1111, 2'd2, 4'd4, 1'b0));
      exp_q.push_back(ev("full_toggle", 4'b0000, 2'd2, 4'd4, 1'b0));
      tick(9);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      tick(1);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      tick(19);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      tick(1);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      exp_q.push_back(ev("blink_to_bounce", 4'b1110, 2'd3, 4'd4, 1'b0));
      exp_q.push_back(ev("bounce_to_off", 4'b1111, 2'd0, 4'd4, 1'b0));
      exp_q.push_back(ev("off_to_flow", 4'b1110, 2'd1, 4'd4, 1'b0));
      for (int i = 0; i < 3; i++) begin
         pulse(4'b0001);
         e = exp_q.pop_front(); n_cmp++;
         if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      end
      exp_q.push_back(ev("up_dn_same", 4'b1110, 2'd1, 4'd4, 1'b0));
      pulse(4'b0110);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      exp_q.push_back(ev("pre_step", 4'b1110, 2'd1, 4'd4, 1'b0));
      tick(18);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      // Mode change lands on the step edge: BLINK entry, not a FLOW step.
      exp_q.push_back(ev("mode_vs_step", 4'b0000, 2'd2, 4'd4, 1'b0));
      pulse(4'b0001);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      exp_q.push_back(ev("cleared_hold", 4'b0000, 2'd2, 4'd4, 1'b0));
      tick(19);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      // Pause lands on the step edge: step applied, then frozen.
      exp_q.push_back(ev("pause_vs_step", 4'b1111, 2'd2, 4'd4, 1'b1));
      pulse(4'b1000);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      exp_q.push_back(ev("pause_frozen", 4'b1111, 2'd2, 4'd4, 1'b1));
      tick(20);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      exp_q.push_back(ev("unpause", 4'b1111, 2'd2, 4'd4, 1'b0));
      pulse(4'b1000);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
   endtask

   task automatic test_wrap();
      exp_t e;
      exp_q.push_back(ev("wrap_reset", 4'b1111, 2'd0, 4'd4, 1'b0));
      rest = 1'b0;
      tick(1);
      rest = 1'b1;
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      exp_q.push_back(ev("wrap_flow", 4'b1110, 2'd1, 4'd4, 1'b0));
      exp_q.push_back(ev("wrap_blink", 4'b0000, 2'd2, 4'd4, 1'b0));
      exp_q.push_back(ev("wrap_bounce", 4'b1110, 2'd3, 4'd4, 1'b0));
      exp_q.push_back(ev("wrap_off", 4'b1111, 2'd0, 4'd4, 1'b0));
      for (int i = 0; i < 4; i++) begin
         pulse(4'b0001);
         e = exp_q.pop_front(); n_cmp++;
         if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      end
   endtask

   initial begin
      rest = 1'b0;
      key_pulse = 4'b0000;
      @(negedge clk);
      test_reset();
      test_flow();
      test_bounce();
      test_pause();
      test_simultaneous();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
